tis_output_node: RTL and testbench
==================================

# tis_output_node

Grid-edge sink that takes values from the adjacent execution or stack node over the grid read handshake. It buffers them in a small FIFO and presents them to host logic as a sign-extended valid/ready stream. It is the downstream terminus of a grid column and turns TIS 11-bit port traffic into a host-readable output stream.

## Interface
Parameters:
- DEPTH, 4: FIFO entries. Power of two, 2..16.
- HOST_W, 16: host data width, ≥11. Values are sign-extended from 11 bits.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_rready  input  1  upstream holds a value for this node on in_data (level)
- in_data  input  11  signed value offered by upstream
- in_read  output  1  one-cycle pulse: value on in_data taken this cycle
- host_valid  output  1  FIFO head is available on host_data
- host_ready  input  1  host accepts host_data this cycle
- host_data  output  HOST_W  sign-extended FIFO head
- fifo_level  output  $clog2(DEPTH)+1  current occupancy
- out_count  output  16  number of host transfers completed, wraps at 65535→0

## Operation
- Storage: DEPTH×11 array, write pointer wp, read pointer rp, occupancy lvl. Pointers wrap modulo DEPTH.
- Grid intake uses a two-state FSM:
  - IDLE: if in_rready && lvl != DEPTH at the clock edge, then in_read<=1, mem[wp]<=in_data, wp<=wp+1, and go to COOL.
  - COOL: in_read<=0 and in_rready is ignored. Go to IDLE unconditionally.
  - COOL exists because upstream drops in_rready only after it sees in_read. It prevents a double take of the same value.
- Host side: host_valid = (lvl != 0). host_data = sign-extend(mem[rp]) to HOST_W.
- A host transfer occurs when host_valid && host_ready at the edge. It advances rp and increments out_count.
- Occupancy update: lvl <= lvl + push − pop. Simultaneous push and pop leaves lvl unchanged.
- Full: lvl == DEPTH blocks intake. There is no same-cycle bypass, so a pop in the same cycle does not enable a push; the push waits one cycle.
- Empty: host_valid is low and host_ready is ignored.
- in_data is sampled only in the cycle the take is decided. Values are stored exactly, including −999 and 999. No saturation.
- All outputs are registers or decode directly from registers. There is no combinational path from in_rready, in_data or host_ready to any output.

## Timing
- Reset values: in_read=0, host_valid=0, host_data=0, fifo_level=0, out_count=0, FSM=IDLE, wp=rp=0. Memory contents are don't-care.
- Reset mid-operation discards buffered values immediately and de-asserts in_read asynchronously.
- Intake latency: with in_rready high and the FIFO not full at edge k, in_read is high in cycle k..k+1 and host_valid is high from edge k if the FIFO was empty.
- Maximum intake rate is one value per 2 cycles. Maximum host drain rate is one value per cycle.
- If in_rready stays high through COOL, the next take occurs at edge k+2. Upstream must have presented a new value by then or dropped in_rready.
- The first host transfer can occur at edge k+1 after the take at edge k.

## Test plan
- Reset, then upstream offers 5 while host_ready=0 → in_read pulses once, then host_valid=1, host_data=0x0005, fifo_level=1, and it holds.
- Upstream offers −999 (11'h419) and the host accepts → host_data=16'hFC19 and out_count=1 after the transfer.
- With host_ready=0, upstream streams 1,2,3,4,5 → four in_read pulses spaced 2 cycles, fifo_level=4, and no fifth in_read while full. Set host_ready=1 → outputs 1,2,3,4,5 in order, with the fifth take occurring one cycle after the first pop.
- Hold in_rready high across COOL with an unchanged value → exactly one in_read per 2 cycles, never on consecutive cycles.
- Simultaneous push and pop at level 2 → fifo_level stays 2 and data order is preserved across pointer wrap after 10 values.
- Assert rst while fifo_level=3 and in_read is high → all outputs return to reset values in the same cycle. After release, a new value 7 appears first on host_data.

Source files
------------

// File: rtl/tis_output_node.sv
// -----------------------------------------------------------------------------
// tis_output_node
//
// Grid-edge sink at the bottom of a grid column. Values offered by the
// adjacent node over the grid read handshake are taken into a small FIFO and
// presented to host logic as a sign-extended valid/ready stream.
//
// Ports:
//   clk         clock
//   rst         asynchronous, active-high reset
//   in_rready   upstream holds a value for this node on in_data (level)
//   in_data     11-bit signed value offered by upstream
//   in_read     one-cycle pulse: value on in_data was taken this cycle
//   host_valid  FIFO head is available on host_data
//   host_ready  host accepts host_data this cycle
//   host_data   FIFO head, sign-extended to HOST_W (zero while empty)
//   fifo_level  current FIFO occupancy
//   out_count   number of completed host transfers, wraps at 16 bits
// -----------------------------------------------------------------------------
module tis_output_node #(
    parameter int DEPTH  = 4,   // power of two, 2..16
    parameter int HOST_W = 16   // >= 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_rready,
    input  logic [10:0]              in_data,
    output logic                     in_read,
    output logic                     host_valid,
    input  logic                     host_ready,
    output logic [HOST_W-1:0]        host_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              out_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_COOL
    } state_t;

    state_t            r_state;
    logic              r_in_read;
    logic [PTR_W-1:0]  r_wp;
    logic [PTR_W-1:0]  r_rp;
    logic [LVL_W-1:0]  r_lvl;
    logic [15:0]       r_out_count;
    logic [10:0]       r_mem [DEPTH];

    logic              w_push;
    logic              w_pop;
    logic              w_not_empty;
    logic [10:0]       w_head;

    // A take is only decided in IDLE; the COOL cycle masks the in_rready
    // that upstream is still holding while it reacts to in_read. Fullness is
    // judged on the current level only, so a pop does not free a slot for a
    // push in the same cycle.
    assign w_not_empty = (r_lvl != '0);
    assign w_push      = (r_state == S_IDLE) && in_rready && (r_lvl != FULL_LVL);
    assign w_pop       = w_not_empty && host_ready;

    // Intake FSM, pointers, occupancy and transfer counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_in_read   <= 1'b0;
            r_wp        <= '0;
            r_rp        <= '0;
            r_lvl       <= '0;
            r_out_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_push) begin
                        r_in_read <= 1'b1;
                        r_wp      <= r_wp + 1'b1;
                        r_state   <= S_COOL;
                    end else begin
                        r_in_read <= 1'b0;
                    end
                end
                S_COOL: begin
                    r_in_read <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_in_read <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase

            if (w_pop) begin
                r_rp        <= r_rp + 1'b1;
                r_out_count <= r_out_count + 16'd1;
            end

            case ({w_push, w_pop})
                2'b10:   r_lvl <= r_lvl + 1'b1;
                2'b01:   r_lvl <= r_lvl - 1'b1;
                default: r_lvl <= r_lvl;
            endcase
        end
    end

    // Storage has no reset: buffered values are discarded by clearing the
    // level and pointers, not the array itself.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wp] <= in_data;
        end
    end

    assign w_head = r_mem[r_rp];

    // host_data is forced to zero while empty so stale array contents never
    // leak out, including straight after reset.
    assign host_data  = w_not_empty ? HOST_W'($signed(w_head)) : '0;
    assign host_valid = w_not_empty;
    assign in_read    = r_in_read;
    assign fifo_level = r_lvl;
    assign out_count  = r_out_count;

endmodule

// File: tb/tb_tis_output_node.sv
// -----------------------------------------------------------------------------
// tb_tis_output_node
//
// Directed scenarios followed by a randomized phase. A reference model keeps
// the FIFO contents as a queue of integers, the cycle of the last take, and
// the transfer count; outputs are compared one cycle at a time, 1 ns after
// each rising edge.
// -----------------------------------------------------------------------------
module tb_tis_output_node;

    localparam int DEPTH  = 4;
    localparam int HOST_W = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_rready;
    logic [10:0]            in_data;
    logic                   in_read;
    logic                   host_valid;
    logic                   host_ready;
    logic [HOST_W-1:0]      host_data;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [15:0]            out_count;

    tis_output_node #(.DEPTH(DEPTH), .HOST_W(HOST_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_rready  (in_rready),
        .in_data    (in_data),
        .in_read    (in_read),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .host_data  (host_data),
        .fifo_level (fifo_level),
        .out_count  (out_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int mq[$];          // buffered values, head first
    int src[$];         // values upstream still has to deliver
    int got[$];         // host_data values seen on host transfers
    int cyc           = 0;
    int last_take     = -10;
    int exp_count     = 0;
    bit prev_read     = 1'b0;
    int n_reads       = 0;
    int first_pop_cyc = -1;
    int last_read_cyc = -1;

    // Sign extension done arithmetically on the integer value
    function automatic logic [15:0] sext(input int v);
        int s;
        s = (v >= 1024) ? v - 2048 : v;
        return 16'(s);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic feed();
        in_rready = (src.size() != 0);
        in_data   = (src.size() != 0) ? 11'(src[0]) : 11'h000;
    endtask

    // One clock: predict from the model, advance, compare all outputs.
    task automatic step(output bit took);
        bit pop;
        took = in_rready && (mq.size() < DEPTH) && ((cyc + 1) - last_take >= 2);
        pop  = (mq.size() != 0) && host_ready;
        if (host_valid && host_ready) begin
            got.push_back(int'(host_data));
            if (first_pop_cyc < 0) first_pop_cyc = cyc + 1;
        end
        if (pop) begin
            void'(mq.pop_front());
            exp_count = (exp_count + 1) % 65536;
        end
        if (took) begin
            mq.push_back(int'(in_data));
            last_take = cyc + 1;
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("in_read",    32'(in_read),    32'(took));
        chk("host_valid", 32'(host_valid), 32'(mq.size() != 0));
        chk("host_data",  32'(host_data),  (mq.size() != 0) ? 32'(sext(mq[0])) : 32'd0);
        chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
        chk("out_count",  32'(out_count),  32'(exp_count));
        chk("no_back_to_back_read", 32'(prev_read && in_read), 32'd0);
        if (in_read) begin
            n_reads++;
            last_read_cyc = cyc;
        end
        prev_read = in_read;
    endtask

    task automatic step_src();
        bit t;
        step(t);
        if (t && src.size() != 0) void'(src.pop_front());
        feed();
    endtask

    task automatic drain();
        int guard;
        host_ready = 1'b1;
        guard = 0;
        while ((mq.size() != 0 || src.size() != 0) && guard < 40) begin
            step_src();
            guard++;
        end
        chk("drain_bound", 32'(mq.size() + src.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit t;
        int guard;

        // ---------------- reset ----------------
        rst        = 1'b1;
        in_rready  = 1'b0;
        in_data    = 11'h000;
        host_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_read",    32'(in_read),    32'd0);
        chk("rst_host_valid", 32'(host_valid), 32'd0);
        chk("rst_host_data",  32'(host_data),  32'd0);
        chk("rst_fifo_level", 32'(fifo_level), 32'd0);
        chk("rst_out_count",  32'(out_count),  32'd0);
        rst = 1'b0;

        // ---------------- single value, host stalled ----------------
        n_reads = 0;
        src.push_back(5);
        feed();
        repeat (6) step_src();
        chk("t1_reads",      32'(n_reads),    32'd1);
        chk("t1_host_data",  32'(host_data),  32'h0005);
        chk("t1_fifo_level", 32'(fifo_level), 32'd1);

        // ---------------- -999 through to host ----------------
        got.delete();
        src.push_back(int'(11'h419));
        feed();
        drain();
        chk("t2_transfers", 32'(got.size()), 32'd2);
        if (got.size() >= 2) chk("t2_neg999", 32'(got[1]), 32'h0000FC19);
        chk("t2_out_count", 32'(out_count), 32'd2);

        // ---------------- fill to full, then drain ----------------
        host_ready = 1'b0;
        got.delete();
        n_reads = 0;
        for (int i = 1; i <= 5; i++) src.push_back(i);
        feed();
        repeat (12) step_src();
        chk("t3_reads_full", 32'(n_reads),    32'd4);
        chk("t3_level_full", 32'(fifo_level), 32'd4);
        first_pop_cyc = -1;
        drain();
        chk("t3_count", 32'(got.size()), 32'd5);
        for (int i = 0; i < 5 && i < got.size(); i++) chk("t3_order", 32'(got[i]), 32'(i + 1));
        chk("t3_fifth_take", 32'(last_read_cyc), 32'(first_pop_cyc + 1));

        // ---------------- in_rready held across COOL ----------------
        host_ready = 1'b1;
        in_rready  = 1'b1;
        in_data    = 11'd9;
        n_reads    = 0;
        repeat (8) step(t);
        chk("t4_reads", 32'(n_reads), 32'd4);
        in_rready = 1'b0;
        drain();

        // ---------------- push+pop at level 2, pointer wrap ----------------
        host_ready = 1'b0;
        src.push_back(10);
        src.push_back(11);
        feed();
        repeat (5) step_src();
        chk("t5_level_start", 32'(fifo_level), 32'd2);
        for (int i = 20; i < 30; i++) src.push_back(i);
        feed();
        guard = 0;
        while (src.size() != 0 && guard < 60) begin
            host_ready = in_rready && ((cyc + 1) - last_take >= 2) && (mq.size() < DEPTH);
            step_src();
            if (host_ready) chk("t5_level_pushpop", 32'(fifo_level), 32'd2);
            guard++;
        end
        host_ready = 1'b0;
        drain();

        // ---------------- asynchronous reset mid-operation ----------------
        host_ready = 1'b0;
        n_reads = 0;
        src.push_back(30);
        src.push_back(31);
        src.push_back(32);
        feed();
        guard = 0;
        while (n_reads < 3 && guard < 20) begin
            step_src();
            guard++;
        end
        chk("t6_pre_read",  32'(in_read),    32'd1);
        chk("t6_pre_level", 32'(fifo_level), 32'd3);
        rst = 1'b1;
        #1;
        chk("t6_rst_in_read",    32'(in_read),    32'd0);
        chk("t6_rst_host_valid", 32'(host_valid), 32'd0);
        chk("t6_rst_host_data",  32'(host_data),  32'd0);
        chk("t6_rst_fifo_level", 32'(fifo_level), 32'd0);
        chk("t6_rst_out_count",  32'(out_count),  32'd0);
        mq.delete();
        src.delete();
        last_take = -10;
        exp_count = 0;
        prev_read = 1'b0;
        feed();
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b0;
        src.push_back(7);
        feed();
        repeat (4) step_src();
        chk("t6_first_after_rst", 32'(host_data), 32'h0007);
        drain();

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 400; i++) begin
            int sel;
            in_rready  = ($urandom_range(0, 3) != 0);
            host_ready = ($urandom_range(0, 2) == 0);
            sel = $urandom_range(0, 9);
            if (sel == 0)      in_data = 11'h3E7;   // 999
            else if (sel == 1) in_data = 11'h419;   // -999
            else               in_data = 11'($urandom);
            step(t);
        end
        in_rready = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
